risc_core_p: RTL

Parametrised VeriRISC core, the successor of the fixed 8-bit/5-bit `risc` top. It keeps the same accumulator ISA and 8-phase instruction cycle. Data and address widths are generalised, and it adds run/step/stop control plus an external program-load and debug-read port. It sits as the top of the processor, with internal memory of 2**AWIDTH words.

---
 rtl/risc_core_p.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/risc_core_p.sv
// Parametrised VeriRISC accumulator core with an 8-phase instruction cycle, run/step/stop
// control, an external program-load port and a combinational debug read port.
module risc_core_p #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              ld_we,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [DWIDTH-1:0] ld_data,
    input  logic [AWIDTH-1:0] dbg_addr,
    output logic [DWIDTH-1:0] dbg_data,
    output logic              halt,
    output logic [AWIDTH-1:0] pc_out,
    output logic [DWIDTH-1:0] ac_out,
    output logic [2:0]        phase_out,
    output logic              instr_done
);

    localparam int unsigned Depth = 2 ** AWIDTH;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    typedef enum logic [1:0] {StStop, StRun, StStep} state_e;

    state_e            state_q;
    logic [2:0]        phase_q;
    logic [AWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] ac_q;
    logic [DWIDTH-1:0] ir_q;
    logic              halt_q;
    logic              instr_done_q;

    logic [DWIDTH-1:0] mem [Depth];

    logic [2:0]        opcode;
    logic [AWIDTH-1:0] ir_addr;
    logic              active;
    logic              alu_op;
    logic              zero;
    logic              sel;
    logic              ld_ir;
    logic              inc_pc;
    logic              ld_pc;
    logic              ld_ac;
    logic              wr;
    logic              data_e;
    logic              halt_op;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] mem_rdata;
    logic [DWIDTH-1:0] alu_out;
    logic [DWIDTH-1:0] bus;

    assign opcode  = ir_q[DWIDTH-1 -: 3];
    assign ir_addr = ir_q[AWIDTH-1:0];
    assign active  = (state_q != StStop);
    assign alu_op  = (opcode == OpAdd) || (opcode == OpAnd) ||
                     (opcode == OpXor) || (opcode == OpLda);
    assign zero    = (ac_q == '0);

    // Phase decoder; everything is idle while stopped.
    always_comb begin
        sel     = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        data_e  = 1'b0;
        halt_op = 1'b0;
        if (active) begin
            unique case (phase_q)
                3'd0, 3'd1: sel = 1'b1;
                3'd2: begin
                    sel   = 1'b1;
                    ld_ir = 1'b1;
                end
                3'd3, 3'd5: ;
                3'd4: begin
                    inc_pc  = 1'b1;
                    halt_op = (opcode == OpHlt);
                end
                3'd6: begin
                    inc_pc = (opcode == OpSkz) && zero;
                    ld_pc  = (opcode == OpJmp);
                    data_e = (opcode == OpSto);
                end
                3'd7: begin
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OpJmp);
                    wr     = (opcode == OpSto);
                    data_e = (opcode == OpSto);
                end
                default: ;
            endcase
        end
    end

    assign addr      = sel ? pc_q : ir_addr;
    assign mem_rdata = mem[addr];

    always_comb begin
        alu_out = ac_q;
        case (opcode)
            OpAdd:   alu_out = ac_q + mem_rdata;
            OpAnd:   alu_out = ac_q & mem_rdata;
            OpXor:   alu_out = ac_q ^ mem_rdata;
            OpLda:   alu_out = mem_rdata;
            default: alu_out = ac_q;
        endcase
    end

    // The ALU drives the bus only while storing; otherwise memory owns it.
    assign bus = data_e ? alu_out : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StStop;
            phase_q      <= 3'd0;
            pc_q         <= '0;
            ac_q         <= '0;
            ir_q         <= '0;
            halt_q       <= 1'b1;
            instr_done_q <= 1'b0;
        end else begin
            instr_done_q <= 1'b0;
            case (state_q)
                StStop: begin
                    if (start) begin
                        state_q <= StRun;
                        halt_q  <= 1'b0;
                    end else if (step) begin
                        state_q <= StStep;
                        halt_q  <= 1'b0;
                    end
                end
                default: begin
                    if (halt_op) begin
                        state_q <= StStop;
                        phase_q <= 3'd0;
                        halt_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                        if (phase_q == 3'd6) begin
                            instr_done_q <= 1'b1;
                        end
                        if (phase_q == 3'd7 && state_q == StStep) begin
                            state_q <= StStop;
                            halt_q  <= 1'b1;
                        end
                    end
                end
            endcase
            if (ld_ir) begin
                ir_q <= bus;
            end
            if (ld_ac) begin
                ac_q <= alu_out;
            end
            if (ld_pc) begin
                pc_q <= ir_addr;
            end else if (inc_pc) begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    // Memory is not reset, but a reset cycle suppresses any write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr) begin
                mem[addr] <= bus;
            end else if (!active && ld_we) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

    assign dbg_data   = mem[dbg_addr];
    assign halt       = halt_q;
    assign pc_out     = pc_q;
    assign ac_out     = ac_q;
    assign phase_out  = phase_q;
    assign instr_done = instr_done_q;

endmodule
